alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute ALU.
- Adds a valid/ready handshake on both sides, registered outputs, set-less-than compares, high-half multiply, and iterative unsigned divide/remainder.
- Sits in the EX stage. The pipeline stalls on ready_o low or valid_o low.
- WIDTH generalises the datapath; 32 is used for RV32 scalar, and narrower widths are used for vector lanes.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 4.
- CTRL_W, 4: width of ALUCtrl_i.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- ALUCtrl_i  input  CTRL_W  operation select.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- data_o  output  WIDTH  registered result.
- zero_o  output  1  registered operands-equal flag.
- busy_o  output  1  iterative operation in progress.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, data_o=0, zero_o=0, valid_o=0, busy_o=0, iteration counter=0.
- Reset during CALC or DONE aborts the operation; the result is discarded and nothing is emitted.
- Opcodes (ALUCtrl_i):
  - 0000 PASS: data1.
  - 0001 SUM: data1 + data2.
  - 0010 SUB: data1 − data2.
  - 0011 AND, 0100 OR, 0101 XOR.
  - 0110 MUL: low WIDTH bits of the product.
  - 0111 MULHU: high WIDTH bits of the unsigned 2*WIDTH product.
  - 1000 DIVU, 1001 REMU.
  - 1010 SLT: signed; result 1 or 0, zero-extended.
  - 1011 SLTU: unsigned.
  - 1100–1111: behave as PASS.
- Arithmetic: SUM/SUB wrap modulo 2^WIDTH; no overflow flag.
- zero_o = (data1_i == data2_i), captured at accept and presented with data_o, for all opcodes.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready_o=1. valid_i=1 is an accept; operands and opcode are latched.
    - Single-cycle op: result and zero are registered; go to DONE (valid_o=1 the next cycle, latency 1).
    - MUL/MULHU/DIVU/REMU: go to CALC, counter=0, busy_o=1.
  - CALC: one iteration per cycle, exactly WIDTH cycles (counter 0..WIDTH-1).
    - Multiply: shift-add.
    - Divide: restoring.
    - When counter==WIDTH-1, the result is registered and the FSM goes to DONE. valid_o=1 exactly WIDTH+1 cycles after accept; busy_o=0 in DONE.
  - DONE: valid_o=1. data_o and zero_o are held stable while ready_i=0. When ready_i=1, go to IDLE with valid_o=0 next cycle.
- ready_o=1 only in IDLE. Requests in CALC/DONE are ignored; the requester must hold valid_i.
- There is no accept in the same cycle as DONE handoff. Best throughput is one op per 2 cycles (single-cycle ops) and one per WIDTH+2 cycles (iterative ops).
- Divide by zero (RISC-V semantics): DIVU returns all ones and REMU returns data1. Still takes WIDTH cycles to keep latency fixed.
- Operand inputs may change after accept without effect.
- valid_i is ignored in the reset cycle.

Decomposition:
- Package alu_pkg: opcode localparams (OP_PASS..OP_SLTU), FSM state encoding (2 bits), CTRL_W default.
- Sub-module alu_muldiv_iter (WIDTH param):
  - Inputs: start, op (mul/mulhu/divu/remu), a, b.
  - Outputs: done pulse after WIDTH cycles, result.
  - Holds the 2*WIDTH accumulator/remainder and the counter.
- The top level holds the FSM, the single-cycle datapath, the output registers, and the handshake.

Test Plan:
- SUB 5,5 (WIDTH=32) -> next cycle valid_o=1, data_o=0, zero_o=1. ADD 0xFFFFFFFF,2 -> data_o=1, zero_o=0.
- SLT 0xFFFFFFFF,1 -> data_o=1. SLTU 0xFFFFFFFF,1 -> data_o=0. Opcode 1110, data1=0xA5 -> data_o=0xA5.
- MUL 7,6 -> busy_o for 32 cycles, valid_o 33 cycles after accept, data_o=42. MULHU 0xFFFFFFFF,0xFFFFFFFF -> data_o=0xFFFFFFFE.
- DIVU 100,7 -> data_o=14. REMU 100,7 -> data_o=2. DIVU 5,0 -> 0xFFFFFFFF. REMU 5,0 -> 5. All with latency 33.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o -> data_o/zero_o stable, ready_o=0, new valid_i ignored. ready_i=1 -> valid_o=0 and ready_o=1 next cycle.
- Assert rst_i on the 10th CALC cycle of MUL -> next cycle state IDLE, valid_o=0, busy_o=0, data_o=0, no result emitted. A following ADD 3,4 -> 7.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: opcodes, FSM encoding
// and the operation select of the iterative multiply/divide unit.
package alu_pkg;

  localparam int CTRL_W_DEF = 4;

  localparam int OP_PASS  = 4'b0000;
  localparam int OP_SUM   = 4'b0001;
  localparam int OP_SUB   = 4'b0010;
  localparam int OP_AND   = 4'b0011;
  localparam int OP_OR    = 4'b0100;
  localparam int OP_XOR   = 4'b0101;
  localparam int OP_MUL   = 4'b0110;
  localparam int OP_MULHU = 4'b0111;
  localparam int OP_DIVU  = 4'b1000;
  localparam int OP_REMU  = 4'b1001;
  localparam int OP_SLT   = 4'b1010;
  localparam int OP_SLTU  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between the EX-stage pipeline and alu_mc.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = CTRL_W_DEF
);

  logic              valid_i;
  logic              ready_o;
  logic [WIDTH-1:0]  data1_i;
  logic [WIDTH-1:0]  data2_i;
  logic [CTRL_W-1:0] ALUCtrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [WIDTH-1:0]  data_o;
  logic              zero_o;
  logic              busy_o;

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    output ready_o, valid_o, data_o, zero_o, busy_o
  );

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
    input  ready_o, valid_o, data_o, zero_o, busy_o
  );

endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle for exactly WIDTH cycles; done_o pulses with the final result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  // acc holds {product_hi, multiplier/product_lo} or {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;
  md_op_e             op_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic               last;

  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign done_o = run_q & last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= b_q);
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    acc_d     = acc_q;
    case (op_q)
      MD_MUL, MD_MULHU: acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      default:          acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], div_ge};
    endcase
  end

  always_comb begin
    result_o = acc_d[WIDTH-1:0];
    case (op_q)
      MD_MULHU, MD_REMU: result_o = acc_d[2*WIDTH-1:WIDTH];
      default:           result_o = acc_d[WIDTH-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      op_q  <= MD_MUL;
    end else if (start_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      op_q  <= op_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: valid/ready on both sides, registered result and
// zero flag, single-cycle logic/compare ops and iterative mul/div.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  alu_mc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic             is_iter;
  md_op_e           md_op;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  always_comb begin
    alu_res = bus.data1_i;
    is_iter = 1'b0;
    md_op   = MD_MUL;
    case (bus.ALUCtrl_i)
      CTRL_W'(OP_PASS):  alu_res = bus.data1_i;
      CTRL_W'(OP_SUM):   alu_res = bus.data1_i + bus.data2_i;
      CTRL_W'(OP_SUB):   alu_res = bus.data1_i - bus.data2_i;
      CTRL_W'(OP_AND):   alu_res = bus.data1_i & bus.data2_i;
      CTRL_W'(OP_OR):    alu_res = bus.data1_i | bus.data2_i;
      CTRL_W'(OP_XOR):   alu_res = bus.data1_i ^ bus.data2_i;
      CTRL_W'(OP_MUL):   begin is_iter = 1'b1; md_op = MD_MUL;   end
      CTRL_W'(OP_MULHU): begin is_iter = 1'b1; md_op = MD_MULHU; end
      CTRL_W'(OP_DIVU):  begin is_iter = 1'b1; md_op = MD_DIVU;  end
      CTRL_W'(OP_REMU):  begin is_iter = 1'b1; md_op = MD_REMU;  end
      CTRL_W'(OP_SLT):   alu_res = {{(WIDTH-1){1'b0}},
                                    ($signed(bus.data1_i) < $signed(bus.data2_i))};
      CTRL_W'(OP_SLTU):  alu_res = {{(WIDTH-1){1'b0}}, (bus.data1_i < bus.data2_i)};
      default:           alu_res = bus.data1_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          zero_d = (bus.data1_i == bus.data2_i);
          if (is_iter) begin
            md_start = 1'b1;
            state_d  = ST_CALC;
          end else begin
            data_d  = alu_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (md_done) begin
          data_d  = md_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // No accept on the handoff cycle; the next request waits for IDLE.
        if (bus.ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (bus.data1_i),
    .b_i      (bus.data2_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.valid_o = (state_q == ST_DONE);
  assign bus.busy_o  = (state_q == ST_CALC);
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table, randomised ops against a
// behavioural model, and hand-written backpressure and reset-abort sequences.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic         exp_z;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  alu_mc_if #(.WIDTH(W), .CTRL_W(4)) bus ();

  alu_mc #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    exp_t r;
    p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r.z = (a == b);
    case (c)
      4'd1:    r.d = a + b;
      4'd2:    r.d = a - b;
      4'd3:    r.d = a & b;
      4'd4:    r.d = a | b;
      4'd5:    r.d = a ^ b;
      4'd6:    r.d = p[W-1:0];
      4'd7:    r.d = p[2*W-1:W];
      4'd8:    r.d = (b == 0) ? {W{1'b1}} : a / b;
      4'd9:    r.d = (b == 0) ? a : a % b;
      4'd10:   r.d = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd11:   r.d = {{(W-1){1'b0}}, (a < b)};
      default: r.d = a;
    endcase
    return r;
  endfunction

  // Issues one request from IDLE with ready_i high and checks latency, busy
  // duration and the scoreboarded result.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int exp_lat, input string name);
    int   lat;
    int   busy_n;
    exp_t got;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
    bus.valid_i   = 1'b1;
    bus.ready_i   = 1'b1;
    sb_q.push_back(e);
    tick();
    bus.valid_i = 1'b0;
    bus.data1_i = $urandom;
    bus.data2_i = $urandom;
    lat    = 1;
    busy_n = 0;
    while (!bus.valid_o && lat < 200) begin
      if (bus.busy_o) busy_n++;
      tick();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_n), (exp_lat == 1) ? 64'd0 : 64'(W));
    got = sb_q.pop_front();
    check({name, " data"}, 64'(bus.data_o), 64'(got.d));
    check({name, " zero"}, 64'(bus.zero_o), 64'(got.z));
    tick();
    check({name, " ready after handoff"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   seen;
    exp_t e;
    logic [3:0]   rc;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{4'h2, 32'd5,        32'd5,        32'd0,        1'b1, 1};
    vecs[1]  = '{4'h1, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1};
    vecs[2]  = '{4'hA, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1};
    vecs[3]  = '{4'hB, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1};
    vecs[4]  = '{4'hE, 32'h000000A5, 32'd3,        32'h000000A5, 1'b0, 1};
    vecs[5]  = '{4'h0, 32'h00001234, 32'h00001234, 32'h00001234, 1'b1, 1};
    vecs[6]  = '{4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1};
    vecs[7]  = '{4'h4, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1};
    vecs[8]  = '{4'h5, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1};
    vecs[9]  = '{4'h6, 32'd7,        32'd6,        32'd42,       1'b0, W + 1};
    vecs[10] = '{4'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, W + 1};
    vecs[11] = '{4'h8, 32'd100,      32'd7,        32'd14,       1'b0, W + 1};
    vecs[12] = '{4'h9, 32'd100,      32'd7,        32'd2,        1'b0, W + 1};
    vecs[13] = '{4'h8, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, W + 1};
    vecs[14] = '{4'h9, 32'd5,        32'd0,        32'd5,        1'b0, W + 1};
    vecs[15] = '{4'hA, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1};
    vecs[16] = '{4'h2, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1};

    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    bus.ALUCtrl_i = '0;
    tick();
    bus.ALUCtrl_i = 4'h1;
    bus.valid_i   = 1'b1;
    tick();
    check("reset ready_o", 64'(bus.ready_o), 64'd1);
    check("reset valid_o", 64'(bus.valid_o), 64'd0);
    check("reset busy_o",  64'(bus.busy_o),  64'd0);
    check("reset data_o",  64'(bus.data_o),  64'd0);
    check("reset zero_o",  64'(bus.zero_o),  64'd0);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    tick();
    check("valid_i ignored in reset", 64'(bus.valid_o), 64'd0);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, '{vecs[i].exp_d, vecs[i].exp_z},
             vecs[i].lat, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 0) rb = ra;
      e  = model(rc, ra, rb);
      lat = (rc inside {4'h6, 4'h7, 4'h8, 4'h9}) ? W + 1 : 1;
      run_op(rc, ra, rb, e, lat, $sformatf("rand%0d op%0h", i, rc));
    end

    // Backpressure: result held while ready_i is low; requests meanwhile ignored.
    bus.ready_i   = 1'b0;
    bus.ALUCtrl_i = 4'h1;
    bus.data1_i   = 32'd10;
    bus.data2_i   = 32'd10;
    bus.valid_i   = 1'b1;
    sb_q.push_back('{32'd20, 1'b1});
    tick();
    bus.ALUCtrl_i = 4'h5;
    bus.data1_i   = 32'h1111;
    bus.data2_i   = 32'h2222;
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d valid_o", i), 64'(bus.valid_o), 64'd1);
      check($sformatf("bp%0d data_o", i),  64'(bus.data_o),  64'(e.d));
      check($sformatf("bp%0d zero_o", i),  64'(bus.zero_o),  64'(e.z));
      check($sformatf("bp%0d ready_o", i), 64'(bus.ready_o), 64'd0);
      tick();
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b0;
    tick();
    check("bp release valid_o", 64'(bus.valid_o), 64'd0);
    check("bp release ready_o", 64'(bus.ready_o), 64'd1);
    tick();
    check("bp no ghost accept", 64'(bus.valid_o), 64'd0);

    // Reset on the 10th CALC cycle of a MUL aborts it with no result emitted.
    bus.ALUCtrl_i = 4'h6;
    bus.data1_i   = 32'd7;
    bus.data2_i   = 32'd6;
    bus.valid_i   = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("abort busy in CALC", 64'(bus.busy_o), 64'd1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready_o", 64'(bus.ready_o), 64'd1);
    check("abort valid_o", 64'(bus.valid_o), 64'd0);
    check("abort busy_o",  64'(bus.busy_o),  64'd0);
    check("abort data_o",  64'(bus.data_o),  64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.valid_o) seen++;
    end
    check("abort nothing emitted", 64'(seen), 64'd0);
    run_op(4'h1, 32'd3, 32'd4, '{32'd7, 1'b0}, 1, "post-abort add");

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
